// File: rtl/id_imm_stage_pkg.sv
// rtl/id_imm_stage_pkg.sv - shared widths, opcodes, one-hot format indices and stage encoding
package id_imm_stage_pkg;

  localparam int XLEN_BUS = 64;
  localparam int INST_BUS = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  // One-hot immediate format vector is {B,I,J,S,U}
  localparam int INST_TYPE_W = 5;
  localparam int INST_TYPE_B = 4;
  localparam int INST_TYPE_I = 3;
  localparam int INST_TYPE_J = 2;
  localparam int INST_TYPE_S = 1;
  localparam int INST_TYPE_U = 0;

  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,
    STAGE_ONE   = 2'd1,
    STAGE_FULL  = 2'd2
  } stage_e;

endpackage

// File: rtl/instr_sign_ext.sv
// rtl/instr_sign_ext.sv - immediate extraction and sign extension to XLEN
module instr_sign_ext
  import id_imm_stage_pkg::*;
#(
  parameter int XLEN = XLEN_BUS
) (
  input  logic [31:0]            instr_i,
  input  logic [INST_TYPE_W-1:0] instr_type_i,
  output logic [XLEN-1:0]        imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      instr_type_i[INST_TYPE_I]: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      instr_type_i[INST_TYPE_S]: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      instr_type_i[INST_TYPE_B]: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                          instr_i[30:25], instr_i[11:8], 1'b0};
      instr_type_i[INST_TYPE_U]: imm32 = {instr_i[31:12], 12'h000};
      instr_type_i[INST_TYPE_J]: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                          instr_i[20], instr_i[30:21], 1'b0};
      default:                   imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm_o = imm32;
    end
  endgenerate

endmodule

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - opcode to one-hot immediate format and illegal flag
module opcode_classifier
  import id_imm_stage_pkg::*;
(
  input  logic [6:0]             opcode_i,
  output logic [INST_TYPE_W-1:0] instr_type_o,
  output logic                   illegal_o
);

  always_comb begin
    instr_type_o = '0;
    illegal_o    = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC:                 instr_type_o[INST_TYPE_U] = 1'b1;
      OPC_JAL:                            instr_type_o[INST_TYPE_J] = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_OP_IMM32, OPC_SYSTEM, OPC_FENCE: instr_type_o[INST_TYPE_I] = 1'b1;
      OPC_BRANCH:                         instr_type_o[INST_TYPE_B] = 1'b1;
      OPC_STORE:                          instr_type_o[INST_TYPE_S] = 1'b1;
      OPC_OP, OPC_OP32:                   instr_type_o = '0;
      // Includes every word whose low two bits are not 2'b11
      default:                            illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_imm_stage.sv
// rtl/id_imm_stage.sv - decode front end: classify, build immediate, two-entry skid buffer
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_W-1:0]      in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INST_W-1:0]      out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [INST_TYPE_W-1:0] out_instr_type,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_illegal
);

  logic [INST_TYPE_W-1:0] type_d;
  logic                   illegal_d;
  logic [XLEN-1:0]        imm_d;

  opcode_classifier u_classifier (
    .opcode_i     (in_instr[6:0]),
    .instr_type_o (type_d),
    .illegal_o    (illegal_d)
  );

  instr_sign_ext #(.XLEN(XLEN)) u_sign_ext (
    .instr_i      (in_instr),
    .instr_type_i (type_d),
    .imm_o        (imm_d)
  );

  stage_e                 state_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic [INST_W-1:0]      main_instr_q, skid_instr_q;
  logic [XLEN-1:0]        main_pc_q,    skid_pc_q;
  logic [INST_TYPE_W-1:0] main_type_q,  skid_type_q;
  logic [XLEN-1:0]        main_imm_q,   skid_imm_q;
  logic                   main_ill_q,   skid_ill_q;

  logic acc, pop;
  assign acc = in_valid & in_ready_q;
  assign pop = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STAGE_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_type_q  <= '0;
      main_imm_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_type_q  <= '0;
      skid_imm_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= STAGE_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        STAGE_EMPTY: begin
          if (acc) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
            main_type_q  <= type_d;
            main_imm_q   <= imm_d;
            main_ill_q   <= illegal_d;
            state_q      <= STAGE_ONE;
            out_valid_q  <= 1'b1;
          end
        end
        STAGE_ONE: begin
          if (acc && pop) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
            main_type_q  <= type_d;
            main_imm_q   <= imm_d;
            main_ill_q   <= illegal_d;
          end else if (acc) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
            skid_type_q  <= type_d;
            skid_imm_q   <= imm_d;
            skid_ill_q   <= illegal_d;
            state_q      <= STAGE_FULL;
            in_ready_q   <= 1'b0;
          end else if (pop) begin
            state_q     <= STAGE_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        STAGE_FULL: begin
          if (pop) begin
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            main_type_q  <= skid_type_q;
            main_imm_q   <= skid_imm_q;
            main_ill_q   <= skid_ill_q;
            state_q      <= STAGE_ONE;
            in_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= STAGE_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_instr      = main_instr_q;
  assign out_pc         = main_pc_q;
  assign out_instr_type = main_type_q;
  assign out_imm        = main_imm_q;
  assign out_illegal    = main_ill_q;

endmodule

// File: tb/tb_id_imm_stage.sv
// tb/tb_id_imm_stage.sv - scoreboard bench for id_imm_stage
module tb_id_imm_stage;

  localparam logic [4:0] T_B = 5'b10000, T_I = 5'b01000, T_J = 5'b00100,
                         T_S = 5'b00010, T_U = 5'b00001, T_0 = 5'b00000;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  typ;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [4:0]  out_instr_type;
  logic [63:0] out_imm;
  logic        out_illegal;

  id_imm_stage #(.XLEN(64), .INST_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_instr_type(out_instr_type), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  exp_t sb[$];
  exp_t pend;
  logic last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    e.instr = i; e.pc = pc; e.typ = T_0; e.imm = '0; e.ill = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: e.typ = T_U;
      7'b1101111:             e.typ = T_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0011011, 7'b1110011, 7'b0001111: e.typ = T_I;
      7'b1100011:             e.typ = T_B;
      7'b0100011:             e.typ = T_S;
      7'b0110011, 7'b0111011: e.typ = T_0;
      default:                e.ill = 1'b1;
    endcase
    case (e.typ)
      T_I: e.imm = {{52{i[31]}}, i[31:20]};
      T_S: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      T_B: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_U: e.imm = {{32{i[31]}}, i[31:12], 12'h000};
      T_J: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  task automatic offer(input logic [31:0] i, input logic [63:0] pc,
                       input logic [4:0] typ, input logic [63:0] imm, input logic ill);
    in_valid = 1'b1; in_instr = i; in_pc = pc;
    pend.instr = i; pend.pc = pc; pend.typ = typ; pend.imm = imm; pend.ill = ill;
  endtask

  task automatic offer_model(input logic [31:0] i, input logic [63:0] pc);
    in_valid = 1'b1; in_instr = i; in_pc = pc;
    pend = model(i, pc);
  endtask

  // Compare the held entry, retire on pop, enqueue on accept, then advance one edge
  task automatic cycle();
    logic acc, pop;
    if (out_valid) begin
      if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else begin
        check("instr", {32'h0, out_instr}, {32'h0, sb[0].instr});
        check("pc", out_pc, sb[0].pc);
        check("type", {59'h0, out_instr_type}, {59'h0, sb[0].typ});
        check("imm", out_imm, sb[0].imm);
        check("illegal", {63'h0, out_illegal}, {63'h0, sb[0].ill});
      end
    end
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop && sb.size() > 0) begin
      void'(sb.pop_front());
      n_pop++;
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(pend);
    last_acc = acc && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) cycle();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [6:0] ops [16];

  initial begin
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b0011011, 7'b1110011, 7'b0001111, 7'b1100011, 7'b0100011, 7'b0110011,
            7'b0111011, 7'b1111111, 7'b0110100, 7'b1010111};

    #12;
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd1);
    check("rst_instr", {32'h0, out_instr}, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_type", {59'h0, out_instr_type}, 64'd0);
    check("rst_illegal", {63'h0, out_illegal}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back with downstream always ready
    out_ready = 1'b1;
    offer(32'h123450B7, 64'h1000, T_U, 64'h0000000012345000, 1'b0); cycle();
    check("lui_latency", {63'h0, out_valid}, 64'd1);
    offer(32'hFFF00093, 64'h1004, T_I, 64'hFFFFFFFFFFFFFFFF, 1'b0); cycle();
    offer(32'hFE000EE3, 64'h1008, T_B, 64'hFFFFFFFFFFFFFFFC, 1'b0); cycle();
    check("beq_next_cycle", {32'h0, out_instr}, 64'hFE000EE3);
    offer(32'hFE002C23, 64'h100C, T_S, 64'hFFFFFFFFFFFFFFF8, 1'b0); cycle();
    offer(32'h002081B3, 64'h1010, T_0, 64'h0, 1'b0); cycle();
    offer(32'h0000007F, 64'h1014, T_0, 64'h0, 1'b1); cycle();
    offer(32'h8000006F, 64'h1018, T_J, 64'hFFFFFFFFFFF00000, 1'b0); cycle();
    drain();

    // Backpressure: two accepted, third held until space frees
    out_ready = 1'b0;
    offer(32'h00100093, 64'h2000, T_I, 64'h1, 1'b0); cycle();
    check("bp_ready_after_1", {63'h0, in_ready}, 64'd1);
    offer(32'h00200113, 64'h2004, T_I, 64'h2, 1'b0); cycle();
    check("bp_ready_after_2", {63'h0, in_ready}, 64'd0);
    offer(32'h00300193, 64'h2008, T_I, 64'h3, 1'b0); cycle();
    check("bp_third_held", {63'h0, last_acc}, 64'd0);
    check("bp_ready_hold", {63'h0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_acc) break;
    end
    check("bp_third_accepted", {63'h0, last_acc}, 64'd1);
    drain();

    // Flush from FULL with a competing offer
    out_ready = 1'b0;
    offer(32'h00400213, 64'h3000, T_I, 64'h4, 1'b0); cycle();
    offer(32'h00500293, 64'h3004, T_I, 64'h5, 1'b0); cycle();
    check("fl_full", {63'h0, in_ready}, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00600313;
    cycle();
    flush = 1'b0;
    check("fl_out_valid", {63'h0, out_valid}, 64'd0);
    check("fl_in_ready", {63'h0, in_ready}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("fl_no_ghost", {63'h0, out_valid}, 64'd0);
    end

    // Asynchronous reset in FULL
    out_ready = 1'b0;
    offer(32'h00700393, 64'h4000, T_I, 64'h7, 1'b0); cycle();
    offer(32'h00800413, 64'h4004, T_I, 64'h8, 1'b0); cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {63'h0, out_valid}, 64'd0);
    check("ar_in_ready", {63'h0, in_ready}, 64'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(32'h00900493, 64'h4008, T_I, 64'h9, 1'b0); cycle();
    check("ar_first_out", {32'h0, out_instr}, 64'h00900493);
    drain();

    // Random traffic against the reference model
    for (int k = 0; k < 200; k++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        offer_model({$urandom()} & 32'hFFFFFF80 | {25'h0, ops[$urandom_range(0, 15)]},
                    64'h8000_0000 + 64'(k * 4));
      else in_valid = 1'b0;
      cycle();
    end
    drain();
    check("pops_nonzero", 64'(n_pop > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_imm_stage.md
# id_imm_stage

Decode-stage front end between the fetch buffer and the execute/issue stage. Each accepted 32-bit instruction is classified into a one-hot immediate format (B/I/J/S/U) from its opcode. The existing immediate generator `instr_sign_ext` produces the sign-extended immediate. Instruction, PC, format and immediate are held in a two-entry skid-buffered pipeline register with valid/ready handshakes on both sides and a synchronous flush.

## Interface
Parameters:
- `XLEN`, 64 — datapath width; 32 selects RV32 behaviour (the `RV64` define is consistent with it).
- `INST_W`, 32 — instruction width; fixed.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — synchronous pipeline kill from branch/trap resolution.
- `in_valid`  in  1  — fetch offers an instruction.
- `in_ready`  out  1  — stage can accept; registered.
- `in_instr`  in  32  — instruction word.
- `in_pc`  in  XLEN  — instruction PC.
- `out_valid`  out  1  — decoded entry available.
- `out_ready`  in  1  — downstream accepts.
- `out_instr`  out  32  — held instruction.
- `out_pc`  out  XLEN  — held PC.
- `out_instr_type`  out  5  — one-hot {B,I,J,S,U} at the shared package indices; all-zero for R-type and illegal.
- `out_imm`  out  XLEN  — sign-extended immediate; 0 when the type is all-zero.
- `out_illegal`  out  1  — opcode not recognised.

## Operation
- Classification from `in_instr[6:0]`, computed combinationally before capture:
  - U: 0110111, 0010111.
  - J: 1101111.
  - I: 1100111, 0000011, 0010011, 0011011, 1110011, 0001111.
  - B: 1100011.
  - S: 0100011.
  - R (type 0, not illegal): 0110011, 0111011.
  - Any other opcode, or `instr[1:0]` != 2'b11: type 0, illegal=1.
- The immediate comes from `instr_sign_ext` on the input side. The stored entry carries the finished immediate, so no immediate logic sits on the output path.
- Buffer states:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: main slot valid, `in_ready`=1.
  - FULL: main and skid slots valid, `in_ready`=0.
- Transitions (acc = `in_valid`&`in_ready`, pop = `out_valid`&`out_ready`):
  - EMPTY: acc → ONE.
  - ONE: acc&!pop → FULL (input goes to skid); acc&pop → ONE (input replaces main); !acc&pop → EMPTY.
  - FULL: pop → ONE (skid moves to main); otherwise hold.
- Outputs are always driven from the main slot. Program order is preserved.
- `flush`=1: next state EMPTY and both slots invalidated. It overrides any acc/pop in the same cycle; an input offered that cycle is dropped. A pop in the flush cycle still completes downstream.
- Slot data registers change only when their slot is written. Data under `out_valid`=0 is don't-care, except at reset.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N.
- Throughput: one instruction per cycle when `out_ready`=1.
- `in_ready` is a pure register output. It falls only on entering FULL, which gives one cycle of skid.
- Reset values (asynchronous):
  - State EMPTY, `out_valid`=0, `in_ready`=1.
  - `out_instr`, `out_pc`, `out_imm`, `out_instr_type` = 0; `out_illegal`=0.
- Reset asserted mid-transfer discards all entries immediately. The first accept after deassertion is allowed on the first rising edge.
- `out_*` data stays stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package (`params.v` defines), reused rather than redefined:
  - Opcode constants.
  - `INST_TYPE` one-hot indices.
  - `XLEN_BUS`/`INST_BUS` widths.
- A new `STAGE_EMPTY/ONE/FULL` 2-bit encoding belongs in the package as well.
- Sub-modules:
  - `instr_sign_ext`, instantiated once.
  - `opcode_classifier`, a new combinational sub-module producing the type and illegal flag, reusable by the compressed-instruction path.

## Test plan
- LUI 0x123450B7, `out_ready`=1 → after 1 cycle: type U, `out_imm`=0x0000000012345000, `out_illegal`=0.
- ADDI 0xFFF00093, then BEQ 0xFE000EE3, back-to-back → I with imm 0xFFFFFFFFFFFFFFFF, then B with imm 0xFFFFFFFFFFFFFFFC, on consecutive cycles.
- SW 0xFE002C23 → type S, imm 0xFFFFFFFFFFFFFFF8; ADD 0x002081B3 → type 0, imm 0, illegal 0; word 0x0000007F → illegal=1.
- `out_ready`=0 for 3 cycles while offering 3 instructions:
  - First two accepted, `in_ready`=0 from the 2nd accept edge.
  - After release, outputs are emitted in order with the third accepted once space frees.
- FULL state, then `flush`=1 with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle input never appears.
- `rst_n` pulsed low in FULL state → `out_valid`=0 and `in_ready`=1 immediately (asynchronously). The next accepted instruction is the first output.
